// File: rtl/kw_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package kw_arb_pkg;

  localparam int CREDIT_W = 4;

  typedef logic [CREDIT_W-1:0] credit_t;

  // A zero weight would starve the client, so it is treated as one transfer.
  function automatic logic [31:0] weff(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/kw_arb_rr_pick.sv
// Rotating-priority pick: first request at or above ptr, wrapping around.
module kw_arb_rr_pick #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] thr;
  logic [2*N-1:0] masked;
  logic           found;

  // Upper copy of the request vector covers the wrap past N-1.
  assign dbl    = {req, req};
  assign thr    = {(2*N){1'b1}} << ptr;
  assign masked = dbl & thr;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (masked[j] && !found) begin
        gnt[j % N] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kw_arb_wrr.sv
// Weighted round-robin arbiter with per-client burst credit, request mask and
// grant lock; the grant is combinational from the registered owner state.
module kw_arb_wrr
  import kw_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = CREDIT_W,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N-1:0]          request,
  input  logic [N-1:0]          mask,
  input  logic [N-1:0]          lock,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  accept,
  output logic [N-1:0]          grant,
  output logic [IDX_W-1:0]      grant_index,
  output logic                  granted,
  output logic                  parked,
  output logic                  locked
);

  logic [N-1:0]          cur;
  logic [WEIGHT_W-1:0]   credit;
  logic [IDX_W-1:0]      ptr;

  logic [N-1:0]          eligible;
  logic [N-1:0]          pick;
  logic [N-1:0]          grant_c;
  logic                  own_elig;
  logic                  own_lock;
  logic                  hold;
  logic [WEIGHT_W-1:0]   wsel;
  logic [WEIGHT_W-1:0]   acc_w;
  logic [WEIGHT_W-1:0]   credit_new;
  logic [IDX_W-1:0]      g_idx;
  logic [IDX_W-1:0]      ptr_nxt;

  assign eligible = request & ~mask;
  assign own_elig = |(cur & eligible);
  assign own_lock = |(cur & lock);
  assign hold     = own_elig && ((credit != '0) || own_lock);

  kw_arb_rr_pick #(.N(N)) u_pick (
    .req (eligible),
    .ptr (ptr),
    .gnt (pick)
  );

  assign grant_c = hold ? cur : pick;

  always_comb begin
    wsel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_c[i]) wsel = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign acc_w      = {{(WEIGHT_W-1){1'b0}}, accept};
  assign credit_new = WEIGHT_W'(weff(32'(wsel))) - acc_w;
  assign g_idx      = IDX_W'(onehot_to_idx(32'(grant_c)));
  assign ptr_nxt    = (g_idx == IDX_W'(N-1)) ? '0 : g_idx + IDX_W'(1);

  // Outputs are gated during reset; parked intentionally is not.
  assign grant       = reset_n ? grant_c : '0;
  assign grant_index = IDX_W'(onehot_to_idx(32'(grant)));
  assign granted     = |grant;
  assign parked      = ~|eligible;
  assign locked      = reset_n && hold && own_lock;

  // A non-hold grant always reloads credit, even when the same owner wins again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur    <= '0;
      credit <= '0;
      ptr    <= '0;
    end else if (grant_c == '0) begin
      cur    <= '0;
      credit <= '0;
    end else if (!hold) begin
      cur    <= grant_c;
      credit <= credit_new;
      ptr    <= ptr_nxt;
    end else begin
      credit <= (credit == '0) ? '0 : credit - acc_w;
    end
  end

endmodule

// File: tb/tb_kw_arb_wrr.sv
// Directed table-driven bench for kw_arb_wrr with a few hand-written sequences.
module tb_kw_arb_wrr;

  logic        clock;
  logic        reset_n;
  logic [3:0]  request;
  logic [3:0]  mask;
  logic [3:0]  lock;
  logic [15:0] weight;
  logic        accept;
  logic [3:0]  grant;
  logic [1:0]  grant_index;
  logic        granted;
  logic        parked;
  logic        locked;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [3:0]  msk;
    logic [3:0]  lck;
    logic [15:0] wgt;
    logic        acc;
    logic [3:0]  eg;
    logic        el;
    logic        ep;
  } vec_t;

  vec_t vecs[$];

  kw_arb_wrr #(.N(4), .WEIGHT_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .request     (request),
    .mask        (mask),
    .lock        (lock),
    .weight      (weight),
    .accept      (accept),
    .grant       (grant),
    .grant_index (grant_index),
    .granted     (granted),
    .parked      (parked),
    .locked      (locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic add(input bit rst, input logic [3:0] req, input logic [3:0] msk,
                     input logic [3:0] lck, input logic [15:0] wgt, input logic acc,
                     input logic [3:0] eg, input logic el, input logic ep);
    vec_t v;
    v.rst = rst; v.req = req; v.msk = msk; v.lck = lck; v.wgt = wgt;
    v.acc = acc; v.eg = eg; v.el = el; v.ep = ep;
    vecs.push_back(v);
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eg, input logic el, input logic ep);
    chk({tag, " grant"},       32'(grant),       32'(eg));
    chk({tag, " grant_index"}, 32'(grant_index), 32'(idx_of(eg)));
    chk({tag, " granted"},     32'(granted),     32'(|eg));
    chk({tag, " locked"},      32'(locked),      32'(el));
    chk({tag, " parked"},      32'(parked),      32'(ep));
  endtask

  initial begin
    reset_n = 1'b1;
    request = '0; mask = '0; lock = '0; weight = '0; accept = 1'b0;

    // Reset-time behaviour: outputs forced low, parked follows eligibility.
    #1 reset_n = 1'b0;
    request = 4'b1111; accept = 1'b1;
    #2 check_outs("in_reset_busy", 4'b0000, 1'b0, 1'b0);
    request = 4'b0000;
    #1 check_outs("in_reset_idle", 4'b0000, 1'b0, 1'b1);

    // rst, req, msk, lck, wgt, acc, exp grant, exp locked, exp parked
    add(1, 4'hF, 4'h0, 4'h0, 16'h0000, 1, 4'b0001, 0, 0);
    // weighted rotation {1,2,1,3}
    add(1, 4'hF, 4'h0, 4'h0, 16'h1213, 1, 4'b0001, 0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 16'h1213, 1, 4'b0001, 0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 16'h1213, 1, 4'b0001, 0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 16'h1213, 1, 4'b0010, 0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 16'h1213, 1, 4'b0100, 0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 16'h1213, 1, 4'b0100, 0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 16'h1213, 1, 4'b1000, 0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 16'h1213, 1, 4'b0001, 0, 0);
    // accept stalls
    add(1, 4'h3, 4'h0, 4'h0, 16'h0012, 0, 4'b0001, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 16'h0012, 1, 4'b0001, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 16'h0012, 0, 4'b0001, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 16'h0012, 1, 4'b0001, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 16'h0012, 1, 4'b0010, 0, 0);
    // lock holds past credit, release re-arbitrates at once
    add(1, 4'h6, 4'h0, 4'h2, 16'h0010, 1, 4'b0010, 0, 0);
    add(0, 4'h6, 4'h0, 4'h2, 16'h0010, 1, 4'b0010, 1, 0);
    add(0, 4'h6, 4'h0, 4'h2, 16'h0010, 1, 4'b0010, 1, 0);
    add(0, 4'h6, 4'h0, 4'h0, 16'h0010, 1, 4'b0100, 0, 0);
    // mid-burst drop, reasserted client waits for client 1
    add(1, 4'h3, 4'h0, 4'h0, 16'h0014, 1, 4'b0001, 0, 0);
    add(0, 4'h2, 4'h0, 4'h0, 16'h0014, 0, 4'b0010, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 16'h0014, 0, 4'b0010, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 16'h0014, 1, 4'b0010, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 16'h0014, 1, 4'b0001, 0, 0);
    // mask and zero weights
    add(1, 4'h5, 4'h4, 4'h0, 16'h0000, 1, 4'b0001, 0, 0);
    add(0, 4'h5, 4'h4, 4'h0, 16'h0000, 1, 4'b0001, 0, 0);
    add(0, 4'h5, 4'h4, 4'h0, 16'h0000, 1, 4'b0001, 0, 0);
    add(0, 4'h4, 4'h4, 4'h0, 16'h0000, 1, 4'b0000, 0, 1);
    add(0, 4'h5, 4'h0, 4'h0, 16'h0000, 1, 4'b0100, 0, 0);
    add(0, 4'h5, 4'h0, 4'h0, 16'h0000, 1, 4'b0001, 0, 0);
    add(0, 4'h5, 4'h0, 4'h0, 16'h0000, 1, 4'b0100, 0, 0);
    add(0, 4'h5, 4'h0, 4'h0, 16'h0000, 1, 4'b0001, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      else @(negedge clock);
      request = vecs[i].req;
      mask    = vecs[i].msk;
      lock    = vecs[i].lck;
      weight  = vecs[i].wgt;
      accept  = vecs[i].acc;
      #2 check_outs($sformatf("vec%0d", i), vecs[i].eg, vecs[i].el, vecs[i].ep);
    end

    // Weight lowered mid-burst only matters at the next new grant.
    lock = '0; mask = '0;
    do_reset();
    request = 4'h3; weight = 16'h0013; accept = 1'b1;
    #2 check_outs("wchg0", 4'b0001, 1'b0, 1'b0);
    @(negedge clock); weight = 16'h0011;
    #2 check_outs("wchg1", 4'b0001, 1'b0, 1'b0);
    @(negedge clock);
    #2 check_outs("wchg2", 4'b0001, 1'b0, 1'b0);
    @(negedge clock);
    #2 check_outs("wchg3", 4'b0010, 1'b0, 1'b0);
    @(negedge clock);
    #2 check_outs("wchg4", 4'b0001, 1'b0, 1'b0);
    @(negedge clock);
    #2 check_outs("wchg5", 4'b0010, 1'b0, 1'b0);

    // Lone owner with exhausted credit is re-granted and reloaded from weight.
    do_reset();
    request = 4'h8; weight = 16'h2000; accept = 1'b1;
    #2 check_outs("solo0", 4'b1000, 1'b0, 1'b0);
    @(negedge clock); request = 4'h9;
    #2 check_outs("solo1", 4'b1000, 1'b0, 1'b0);
    @(negedge clock);
    #2 check_outs("solo2", 4'b0001, 1'b0, 1'b0);
    @(negedge clock); request = 4'h8;
    #2 check_outs("solo3", 4'b1000, 1'b0, 1'b0);
    @(negedge clock);
    #2 check_outs("solo4", 4'b1000, 1'b0, 1'b0);
    @(negedge clock);
    #2 check_outs("solo5", 4'b1000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
